rsa_modexp_core: RTL
====================

// Module: rsa_modexp_core
// PURPOSE
//  Parametrised successor of the fixed 256-bit RSA core: computes o_result = i_a^i_d mod i_n, using
//  LSB-first square-and-multiply over Montgomery multiplication. Sits between the RSA wrapper's
//  input/output shift registers. Adds over the 256-bit core: width/exponent parameters, operand
//  latching, a busy flag, an even-modulus error path and exact, deterministic latency.
// PARAMETERS
//  W      256  operand width (bits) of i_a, i_n, o_result; W >= 4
//  E      W    exponent width (bits) of i_d; E >= 1
//  CNT_W  $clog2(W+2)  internal iteration-counter width (derived, not overridden)
// PORTS
//  i_clk       in   1  clock, rising edge
//  i_rst       in   1  reset, asynchronous, active-high
//  i_start     in   1  start request; sampled only in S_IDLE
//  i_a         in   W  base (ciphertext); caller guarantees i_a < i_n
//  i_d         in   E  exponent (private key)
//  i_n         in   W  modulus; must be odd
//  o_result    out  W  a^d mod n; holds until the next accepted start
//  o_finished  out  1  one-cycle pulse when o_result is valid
//  o_busy      out  1  high from the cycle after start acceptance until o_finished
//  o_err       out  1  set with o_finished when i_n was even; cleared on next accepted start
// BEHAVIOUR
//  Reset: state S_IDLE; o_result 0, o_finished 0, o_busy 0, o_err 0; internal m=1, t=0, counters 0.
//  Start acceptance: the cycle with S_IDLE && i_start is cycle 0. i_a, i_d and i_n are latched there
//   and never re-read. i_start outside S_IDLE is ignored (no queueing).
//  States:
//   S_IDLE  on i_start: if i_n[0]==0 -> S_ERR, else -> S_PREP with m=1, t=a, cnt=0
//   S_ERR   one cycle: o_result=0, o_err=1, o_finished=1 -> S_IDLE
//   S_PREP  W cycles: t = (2*t >= n) ? 2*t-n : 2*t, using a (W+1)-bit intermediate;
//           yields t = a*2^W mod n -> S_LOOP
//   S_LOOP  per exponent bit i = 0..E-1, LSB first: on entry, pulse start to two mont_mul
//           instances, mul(m,t) and sqr(t,t); both report done W+1 cycles later. In the done cycle
//           t <= sqr; m <= d[i] ? mul : m; i++. The next bit starts the following cycle, so each
//           bit costs W+2 cycles. Always runs E bits (constant time; no early exit on zero bits).
//   S_DONE  one cycle: o_result=m, o_finished=1, o_busy=0 -> S_IDLE
//  Latency: o_finished is high in cycle W+1+E*(W+2) (even-n path: cycle 1).
//  m stays in the normal domain because mont(m, a*2^W) = m*a mod n; d==0 therefore gives 1.
//  mont_mul: W iterations of r = (r + b_j*a + q*n)/2 with q = parity, using a (W+2)-bit
//   accumulator, then one final conditional subtract of n; output < n.
//  Reset mid-operation: all state returns to reset values at once; o_finished is not emitted for
//   the aborted job; the next start behaves as if from power-up.
//  Start in the same cycle as o_finished: ignored (state is S_DONE/S_ERR, not S_IDLE).
// STRUCTURE
//  rsa_pkg: state_e {S_IDLE,S_ERR,S_PREP,S_LOOP,S_DONE}, shared with the wrapper's FSM debug output.
//  Sub-module mont_mul #(W): i_clk, i_rst, i_start, i_a, i_b, i_n -> o_result, o_done. It is
//   instantiated twice (mul, sqr) and both instances run in lockstep.
//  The top level holds the FSM, the prep doubler, the bit counter and the output registers.
// TESTING (W=8, E=8 unless stated)
//  1. a=2, d=10, n=143, start -> o_finished exactly at cycle 89, o_result=23, o_err=0.
//  2. a=7, d=0, n=143 -> o_result=1 at cycle 89; then a=0, d=5 -> o_result=0.
//  3. n=144 (even) -> o_finished and o_err at cycle 1, o_result=0; next valid job clears o_err.
//  4. Hold i_start high for the whole run and change i_a/i_d/i_n at cycle 5 -> a single result,
//     computed from the inputs latched at cycle 0; o_busy high through cycles 1..88.
//  5. Assert i_rst at cycle 40 -> all outputs 0 the same cycle, no o_finished pulse; a restart
//     then gives the correct result.
//  6. W=256, E=256: random odd n, a<n, d; compare to a software modexp; 1000 runs, 0 mismatches.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types for the RSA modular-exponentiation core and its wrapper.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rsa_pkg;

  // Exponentiation FSM states; the wrapper exports this encoding on its debug port.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_PREP = 3'd2,
    S_LOOP = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mont_mul.sv
// Montgomery multiplier: o_result = i_a * i_b * 2^-W mod i_n, bit-serial over i_b (LSB first).
// Latency: o_done pulses exactly W+1 cycles after the i_start cycle; o_result is valid during o_done.
// Backpressure: none; i_start restarts the unit unconditionally, operands are latched on i_start.
module mont_mul #(
  parameter int W = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_result,
  output logic         o_done
);

  localparam int CW = $clog2(W + 2);

  logic [W-1:0]  a_q, b_q, n_q;
  logic [W+1:0]  r_q;
  logic [CW-1:0] cnt_q;
  logic          run_q, fin_q;
  logic [W+1:0]  r_add, r_sum;

  // One reduction step: add b_j*a, make the sum even by adding n, then halve.
  // The accumulator stays below 2n, so W+2 bits never overflow.
  always_comb begin
    r_add = r_q + (b_q[0] ? {2'b00, a_q} : '0);
    r_sum = r_add + (r_add[0] ? {2'b00, n_q} : '0);
  end

  // Final conditional subtract; when r >= n the difference is below n, so low W bits suffice.
  assign o_result = (r_q >= {2'b00, n_q}) ? (r_q[W-1:0] - n_q) : r_q[W-1:0];
  assign o_done   = fin_q;

  // Operand latch, iteration counter and accumulator.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      fin_q <= 1'b0;
    end else if (i_start) begin
      a_q   <= i_a;
      b_q   <= i_b;
      n_q   <= i_n;
      r_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
      fin_q <= 1'b0;
    end else if (run_q) begin
      r_q   <= r_sum >> 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        run_q <= 1'b0;
        fin_q <= 1'b1;
      end
    end else begin
      fin_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rsa_modexp_core.sv
// Modular exponentiation o_result = i_a^i_d mod i_n, LSB-first square-and-multiply over Montgomery products.
// Latency: o_finished in cycle W+1+E*(W+2) after the accepting cycle (cycle 1 for an even modulus); constant time.
// Backpressure: none; i_start is only honoured in S_IDLE and is dropped otherwise (no queueing).
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int W = 256,
  parameter int E = W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [E-1:0] i_d,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_result,
  output logic         o_finished,
  output logic         o_busy,
  output logic         o_err
);

  localparam int CNT_W = $clog2(W + 2);
  localparam int BIT_W = $clog2(E + 1);

  state_e         state_q, state_d;
  logic [W-1:0]   n_q, m_q, t_q, res_q;
  logic [E-1:0]   d_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_q;
  logic           issue_q, err_q;
  logic           mm_start;
  logic [W-1:0]   mul_res, sqr_res;
  logic           mul_done, sqr_done, bit_done;
  logic [W:0]     t_dbl;
  logic [W-1:0]   t_next;

  // Prep doubler: t = 2t mod n with one extra bit of headroom.
  always_comb begin
    t_dbl  = {t_q, 1'b0};
    t_next = (t_dbl >= {1'b0, n_q}) ? (t_dbl[W-1:0] - n_q) : t_dbl[W-1:0];
  end

  assign bit_done = mul_done & sqr_done;

  // m*t keeps m in the normal domain because t carries the 2^W factor.
  mont_mul #(.W(W)) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (mm_start),
    .i_a     (m_q),
    .i_b     (t_q),
    .i_n     (n_q),
    .o_result(mul_res),
    .o_done  (mul_done)
  );

  // t*t keeps t = a^(2^i) * 2^W mod n for the next exponent bit.
  mont_mul #(.W(W)) u_sqr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (mm_start),
    .i_a     (t_q),
    .i_b     (t_q),
    .i_n     (n_q),
    .o_result(sqr_res),
    .o_done  (sqr_done)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and output drive.
  always_comb begin
    state_d    = state_q;
    o_result   = res_q;
    o_finished = 1'b0;
    o_busy     = 1'b0;
    o_err      = err_q;
    mm_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = i_n[0] ? S_PREP : S_ERR;
      end
      S_ERR: begin
        o_result   = '0;
        o_err      = 1'b1;
        o_finished = 1'b1;
        state_d    = S_IDLE;
      end
      S_PREP: begin
        o_busy = 1'b1;
        if (cnt_q == CNT_W'(W - 1)) state_d = S_LOOP;
      end
      S_LOOP: begin
        o_busy   = 1'b1;
        mm_start = issue_q;
        if (bit_done && (bit_q == BIT_W'(E - 1))) state_d = S_DONE;
      end
      S_DONE: begin
        o_result   = m_q;
        o_finished = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, prep doubling, per-bit m/t update and held result/error flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      n_q     <= '0;
      d_q     <= '0;
      m_q     <= W'(1);
      t_q     <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      issue_q <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            n_q     <= i_n;
            d_q     <= i_d;
            t_q     <= i_a;
            m_q     <= W'(1);
            cnt_q   <= '0;
            bit_q   <= '0;
            issue_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_ERR: begin
          res_q <= '0;
          err_q <= 1'b1;
        end
        S_PREP: begin
          t_q   <= t_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(W - 1)) issue_q <= 1'b1;
        end
        S_LOOP: begin
          issue_q <= 1'b0;
          if (bit_done) begin
            t_q <= sqr_res;
            if (d_q[0]) m_q <= mul_res;
            d_q     <= d_q >> 1;
            bit_q   <= bit_q + 1'b1;
            issue_q <= 1'b1;
          end
        end
        S_DONE: begin
          res_q <= m_q;
        end
        default: ;
      endcase
    end
  end

endmodule
